// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state encoding for the command-level system controller.
package sys_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FUN_W  = 4;

  localparam logic [DATA_W-1:0] OP_WR      = 8'hAA;
  localparam logic [DATA_W-1:0] OP_RD      = 8'hBB;
  localparam logic [DATA_W-1:0] OP_ALU_OP  = 8'hCC;
  localparam logic [DATA_W-1:0] OP_ALU_NOP = 8'hDD;

  localparam logic [ADDR_W-1:0] ADDR_OP_A = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_OP_B = 4'd1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_TX,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    TX_LSB,
    TX_MSB
  } state_t;

endpackage

// File: rtl/sys_ctrl_if.sv
// Bundle of RX, register-file, ALU and TX-FIFO signals around the system controller.
interface sys_ctrl_if;
  import sys_ctrl_pkg::*;

  logic [DATA_W-1:0]   rx_p_data;
  logic                rx_d_vld;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_data_vld;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_out_vld;
  logic                fifo_full;

  logic [FUN_W-1:0]    alu_fun;
  logic                alu_en;
  logic                clk_gate_en;
  logic [ADDR_W-1:0]   addr;
  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   tx_p_data;
  logic                tx_d_vld;

  // The controller is the master; the surrounding system is the slave.
  modport master (
    input  rx_p_data, rx_d_vld, rd_data, rd_data_vld, alu_out, alu_out_vld, fifo_full,
    output alu_fun, alu_en, clk_gate_en, addr, wr_en, rd_en, wr_data, tx_p_data, tx_d_vld
  );

  modport slave (
    output rx_p_data, rx_d_vld, rd_data, rd_data_vld, alu_out, alu_out_vld, fifo_full,
    input  alu_fun, alu_en, clk_gate_en, addr, wr_en, rd_en, wr_data, tx_p_data, tx_d_vld
  );

endinterface

// File: rtl/sys_ctrl.sv
// Parses the RX byte stream into register write/read and ALU commands and
// returns read data and ALU results as bytes into the TX FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  sys_ctrl_if.master bus
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr_hold;
  logic [DATA_W-1:0]   r_rd_byte;
  logic [2*DATA_W-1:0] r_result;

  logic [FUN_W-1:0]    r_alu_fun;
  logic                r_alu_en;
  logic                r_clk_gate_en;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr_en;
  logic                r_rd_en;
  logic [DATA_W-1:0]   r_wr_data;
  logic [DATA_W-1:0]   r_tx_p_data;
  logic                r_tx_d_vld;

  // The write address is held internally so addr only moves together with wr_en.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= IDLE;
      r_addr_hold   <= '0;
      r_rd_byte     <= '0;
      r_result      <= '0;
      r_alu_fun     <= '0;
      r_alu_en      <= 1'b0;
      r_clk_gate_en <= 1'b0;
      r_addr        <= '0;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_wr_data     <= '0;
      r_tx_p_data   <= '0;
      r_tx_d_vld    <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_tx_d_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.rx_d_vld) begin
            case (bus.rx_p_data)
              OP_WR:      r_state <= WR_ADDR;
              OP_RD:      r_state <= RD_ADDR;
              OP_ALU_OP:  r_state <= ALU_A;
              OP_ALU_NOP: r_state <= ALU_FUN;
              default:    r_state <= IDLE;
            endcase
          end
        end
        WR_ADDR: begin
          if (bus.rx_d_vld) begin
            r_addr_hold <= bus.rx_p_data[ADDR_W-1:0];
            r_state     <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (bus.rx_d_vld) begin
            r_addr    <= r_addr_hold;
            r_wr_data <= bus.rx_p_data;
            r_wr_en   <= 1'b1;
            r_state   <= IDLE;
          end
        end
        RD_ADDR: begin
          if (bus.rx_d_vld) begin
            r_addr  <= bus.rx_p_data[ADDR_W-1:0];
            r_rd_en <= 1'b1;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.rd_data_vld) begin
            r_rd_byte <= bus.rd_data;
            r_state   <= RD_TX;
          end
        end
        RD_TX: begin
          if (!bus.fifo_full) begin
            r_tx_p_data <= r_rd_byte;
            r_tx_d_vld  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        ALU_A: begin
          if (bus.rx_d_vld) begin
            r_addr    <= ADDR_OP_A;
            r_wr_data <= bus.rx_p_data;
            r_wr_en   <= 1'b1;
            r_state   <= ALU_B;
          end
        end
        ALU_B: begin
          if (bus.rx_d_vld) begin
            r_addr    <= ADDR_OP_B;
            r_wr_data <= bus.rx_p_data;
            r_wr_en   <= 1'b1;
            r_state   <= ALU_FUN;
          end
        end
        ALU_FUN: begin
          if (bus.rx_d_vld) begin
            r_alu_fun     <= bus.rx_p_data[FUN_W-1:0];
            r_alu_en      <= 1'b1;
            r_clk_gate_en <= 1'b1;
            r_state       <= ALU_WAIT;
          end
        end
        // The ALU is released and its clock gated again as soon as the result is captured.
        ALU_WAIT: begin
          if (bus.alu_out_vld) begin
            r_result      <= bus.alu_out;
            r_alu_en      <= 1'b0;
            r_clk_gate_en <= 1'b0;
            r_state       <= TX_LSB;
          end
        end
        TX_LSB: begin
          if (!bus.fifo_full) begin
            r_tx_p_data <= r_result[DATA_W-1:0];
            r_tx_d_vld  <= 1'b1;
            r_state     <= TX_MSB;
          end
        end
        TX_MSB: begin
          if (!bus.fifo_full) begin
            r_tx_p_data <= r_result[2*DATA_W-1:DATA_W];
            r_tx_d_vld  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.alu_fun     = r_alu_fun;
  assign bus.alu_en      = r_alu_en;
  assign bus.clk_gate_en = r_clk_gate_en;
  assign bus.addr        = r_addr;
  assign bus.wr_en       = r_wr_en;
  assign bus.rd_en       = r_rd_en;
  assign bus.wr_data     = r_wr_data;
  assign bus.tx_p_data   = r_tx_p_data;
  assign bus.tx_d_vld    = r_tx_d_vld;

endmodule

// File: tb/tb_sys_ctrl.sv
// Testbench for sys_ctrl: directed command scenarios followed by randomized
// command streams checked against a transaction-level model of the controller.
module tb_sys_ctrl;
  import sys_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  sys_ctrl_if bus ();

  sys_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic [11:0] wrLog[$];
  logic [11:0] expWr[$];
  logic [3:0]  rdLog[$];
  logic [3:0]  expRd[$];
  logic [7:0]  txLog[$];
  logic [7:0]  expTx[$];
  logic [7:0]  regModel[16];

  // Record every register access and TX push the DUT performs, one entry per strobe cycle.
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.wr_en)    wrLog.push_back({bus.addr, bus.wr_data});
      if (bus.rd_en)    rdLog.push_back(bus.addr);
      if (bus.tx_d_vld) txLog.push_back(bus.tx_p_data);
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one RX byte for exactly one cycle; entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    @(posedge CLK);
    #1;
    bus.rx_d_vld  = 1'b0;
    bus.rx_p_data = 8'($urandom);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [15:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] fun);
    if (fun[3:2] == 2'b00) return 16'(a) + 16'(b);
    else return 16'(a) * 16'(b);
  endfunction

  // Compares everything the DUT did since the last call with what the model expected, then clears both.
  task automatic compareLogs(input string tag);
    checkOutput({tag, " wr count"}, wrLog.size(), expWr.size());
    for (int i = 0; i < wrLog.size() && i < expWr.size(); i++)
      checkOutput($sformatf("%s wr%0d", tag, i), wrLog[i], expWr[i]);
    checkOutput({tag, " rd count"}, rdLog.size(), expRd.size());
    for (int i = 0; i < rdLog.size() && i < expRd.size(); i++)
      checkOutput($sformatf("%s rd%0d", tag, i), rdLog[i], expRd[i]);
    checkOutput({tag, " tx count"}, txLog.size(), expTx.size());
    for (int i = 0; i < txLog.size() && i < expTx.size(); i++)
      checkOutput($sformatf("%s tx%0d", tag, i), txLog[i], expTx[i]);
    wrLog.delete(); expWr.delete();
    rdLog.delete(); expRd.delete();
    txLog.delete(); expTx.delete();
  endtask

  // Write command; stray read/ALU strobes during the address byte must be ignored.
  task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
    logic [3:0] ra;
    ra = a[3:0];
    applyStimulus(OP_WR);
    bus.rd_data     = 8'h99;
    bus.rd_data_vld = 1'b1;
    bus.alu_out     = 16'hBEEF;
    bus.alu_out_vld = 1'b1;
    applyStimulus(a);
    bus.rd_data_vld = 1'b0;
    bus.alu_out_vld = 1'b0;
    applyStimulus(d);
    checkOutput("write wr_en", bus.wr_en, 1'b1);
    checkOutput("write addr", bus.addr, ra);
    checkOutput("write wr_data", bus.wr_data, d);
    expWr.push_back({ra, d});
    regModel[ra] = d;
    idleCycles(1);
    checkOutput("write wr_en width", bus.wr_en, 1'b0);
    checkOutput("write addr hold", bus.addr, ra);
  endtask

  // Read command; an optional junk RX byte arrives while waiting and must be dropped.
  task automatic doRead(input logic [7:0] a, input int k, input bit junk);
    logic [3:0] ra;
    ra = a[3:0];
    applyStimulus(OP_RD);
    applyStimulus(a);
    checkOutput("read rd_en", bus.rd_en, 1'b1);
    checkOutput("read addr", bus.addr, ra);
    expRd.push_back(ra);
    for (int i = 0; i < k; i++) begin
      if (junk && i == 0) applyStimulus(OP_RD);
      else idleCycles(1);
    end
    bus.rd_data     = regModel[ra];
    bus.rd_data_vld = 1'b1;
    @(posedge CLK);
    #1;
    bus.rd_data_vld = 1'b0;
    bus.rd_data     = 8'($urandom);
    checkOutput("read no early push", bus.tx_d_vld, 1'b0);
    idleCycles(1);
    checkOutput("read tx_d_vld", bus.tx_d_vld, 1'b1);
    checkOutput("read tx_p_data", bus.tx_p_data, regModel[ra]);
    expTx.push_back(regModel[ra]);
    idleCycles(1);
    checkOutput("read tx_d_vld width", bus.tx_d_vld, 1'b0);
  endtask

  // ALU command with or without operands; optional FIFO-full window right after capture.
  task automatic doAlu(input bit withOps, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] fun, input int k, input int holdFull);
    logic [15:0] res;
    if (withOps) begin
      applyStimulus(OP_ALU_OP);
      applyStimulus(a);
      applyStimulus(b);
      expWr.push_back({ADDR_OP_A, a});
      expWr.push_back({ADDR_OP_B, b});
      regModel[0] = a;
      regModel[1] = b;
    end else begin
      applyStimulus(OP_ALU_NOP);
    end
    applyStimulus(fun);
    checkOutput("alu alu_en rise", bus.alu_en, 1'b1);
    checkOutput("alu clk_gate_en rise", bus.clk_gate_en, 1'b1);
    checkOutput("alu alu_fun", bus.alu_fun, fun[3:0]);
    res = aluModel(regModel[0], regModel[1], fun[3:0]);
    idleCycles(k);
    checkOutput("alu alu_en held", bus.alu_en, 1'b1);
    bus.alu_out     = res;
    bus.alu_out_vld = 1'b1;
    bus.fifo_full   = (holdFull > 0);
    @(posedge CLK);
    #1;
    bus.alu_out_vld = 1'b0;
    bus.alu_out     = 16'($urandom);
    checkOutput("alu alu_en fall", bus.alu_en, 1'b0);
    checkOutput("alu clk_gate_en fall", bus.clk_gate_en, 1'b0);
    for (int i = 0; i < holdFull; i++) begin
      idleCycles(1);
      checkOutput("alu no push while full", bus.tx_d_vld, 1'b0);
    end
    bus.fifo_full = 1'b0;
    idleCycles(1);
    checkOutput("alu lsb tx_d_vld", bus.tx_d_vld, 1'b1);
    checkOutput("alu lsb tx_p_data", bus.tx_p_data, res[7:0]);
    idleCycles(1);
    checkOutput("alu msb tx_d_vld", bus.tx_d_vld, 1'b1);
    checkOutput("alu msb tx_p_data", bus.tx_p_data, res[15:8]);
    idleCycles(1);
    checkOutput("alu tx_d_vld idle", bus.tx_d_vld, 1'b0);
    checkOutput("alu alu_fun hold", bus.alu_fun, fun[3:0]);
    expTx.push_back(res[7:0]);
    expTx.push_back(res[15:8]);
  endtask

  initial begin
    logic [7:0] a, b, d, f;
    int kind;

    for (int i = 0; i < 16; i++) regModel[i] = 8'h00;
    RST             = 1'b0;
    bus.rx_p_data   = '0;
    bus.rx_d_vld    = 1'b0;
    bus.rd_data     = '0;
    bus.rd_data_vld = 1'b0;
    bus.alu_out     = '0;
    bus.alu_out_vld = 1'b0;
    bus.fifo_full   = 1'b0;
    idleCycles(3);
    checkOutput("reset alu_en", bus.alu_en, 1'b0);
    checkOutput("reset clk_gate_en", bus.clk_gate_en, 1'b0);
    checkOutput("reset alu_fun", bus.alu_fun, 4'h0);
    checkOutput("reset addr", bus.addr, 4'h0);
    checkOutput("reset wr_en", bus.wr_en, 1'b0);
    checkOutput("reset rd_en", bus.rd_en, 1'b0);
    checkOutput("reset wr_data", bus.wr_data, 8'h00);
    checkOutput("reset tx_p_data", bus.tx_p_data, 8'h00);
    checkOutput("reset tx_d_vld", bus.tx_d_vld, 1'b0);
    RST = 1'b1;
    idleCycles(1);

    $display("[TB] directed write/read/alu");
    doWrite(8'h05, 8'h3C);
    compareLogs("write");
    doRead(8'h05, 2, 1'b1);
    compareLogs("read");
    doAlu(1'b1, 8'h12, 8'h34, 8'h00, 2, 0);
    compareLogs("alu ops");
    doAlu(1'b0, 8'h00, 8'h00, 8'h08, 1, 5);
    compareLogs("backpressure");

    applyStimulus(8'h77);
    doWrite(8'h01, 8'hFF);
    compareLogs("illegal opcode");

    doWrite(8'hF3, 8'h5A);
    doRead(8'hA3, 0, 1'b0);
    compareLogs("upper addr bits");

    $display("[TB] reset during ALU wait");
    applyStimulus(OP_ALU_NOP);
    applyStimulus(8'h05);
    idleCycles(1);
    #3;
    RST = 1'b0;
    #1;
    checkOutput("async reset alu_en", bus.alu_en, 1'b0);
    checkOutput("async reset clk_gate_en", bus.clk_gate_en, 1'b0);
    checkOutput("async reset alu_fun", bus.alu_fun, 4'h0);
    checkOutput("async reset addr", bus.addr, 4'h0);
    checkOutput("async reset wr_data", bus.wr_data, 8'h00);
    checkOutput("async reset tx_p_data", bus.tx_p_data, 8'h00);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.alu_out     = 16'h1234;
    bus.alu_out_vld = 1'b1;
    idleCycles(1);
    bus.alu_out_vld = 1'b0;
    idleCycles(4);
    checkOutput("post reset alu_en", bus.alu_en, 1'b0);
    compareLogs("reset abort");

    $display("[TB] randomized command stream");
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom_range(0, 127)));
      kind = $urandom_range(0, 3);
      a = 8'($urandom);
      b = 8'($urandom);
      d = 8'($urandom);
      f = 8'($urandom);
      case (kind)
        0: doWrite(a, d);
        1: doRead(a, $urandom_range(0, 3), 1'($urandom));
        2: doAlu(1'b1, a, b, f, $urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        default: doAlu(1'b0, a, b, f, $urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      endcase
      compareLogs($sformatf("random%0d", n));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command-level system controller that sits directly upstream of the ALU function decoder and the register file. It parses the byte stream from the synchronised UART-RX path into register-write, register-read and ALU commands. It drives `alu_fun`, `alu_en` and the ALU clock-gate enable. It returns read data and ALU results as bytes into the TX FIFO.

## Interface
- `DATA_W`, 8: RX/TX byte and register width.
- `ADDR_W`, 4: register-file address width.
- `FUN_W`, 4: ALU function width; bits [3:2] select the unit in the downstream decoder.

- `CLK`  in  1  system clock; single clock domain.
- `RST`  in  1  asynchronous, active-low reset.
- `rx_p_data`  in  DATA_W  received byte.
- `rx_d_vld`  in  1  one-cycle strobe, `rx_p_data` valid.
- `rd_data`  in  DATA_W  register-file read data.
- `rd_data_vld`  in  1  strobe, `rd_data` valid.
- `alu_out`  in  2*DATA_W  ALU result.
- `alu_out_vld`  in  1  strobe, `alu_out` valid.
- `fifo_full`  in  1  TX FIFO full.
- `alu_fun`  out  FUN_W  ALU function.
- `alu_en`  out  1  ALU enable, feeds decoder `enable_unit`.
- `clk_gate_en`  out  1  ALU clock-gate enable.
- `addr`  out  ADDR_W  register-file address.
- `wr_en`, `rd_en`  out  1  register-file one-cycle strobes.
- `wr_data`  out  DATA_W  register-file write data.
- `tx_p_data`  out  DATA_W  byte to TX FIFO.
- `tx_d_vld`  out  1  TX FIFO write strobe.

## Operation
- Opcodes (first byte):
  - 0xAA: write. Bytes: addr, data.
  - 0xBB: read. Bytes: addr.
  - 0xCC: ALU with operands. Bytes: A, B, fun.
  - 0xDD: ALU, no operands. Bytes: fun.
- Any other first byte is dropped; the FSM stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_TX, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB.
- Transitions:
  - IDLE → WR_ADDR / RD_ADDR / ALU_A / ALU_FUN on 0xAA / 0xBB / 0xCC / 0xDD.
  - WR_ADDR → WR_DATA on the address byte.
  - WR_DATA → IDLE on the data byte, issuing one `wr_en` pulse.
  - RD_ADDR → RD_WAIT on the address byte, issuing one `rd_en` pulse.
  - RD_WAIT → RD_TX on `rd_data_vld`, capturing `rd_data`.
  - RD_TX → IDLE once the byte is pushed.
  - ALU_A writes the operand to address 0 → ALU_B.
  - ALU_B writes the operand to address 1 → ALU_FUN.
  - ALU_FUN latches `alu_fun` from byte[FUN_W-1:0], sets `clk_gate_en` and `alu_en` → ALU_WAIT.
  - ALU_WAIT captures `alu_out` on `alu_out_vld`, clears `alu_en` and `clk_gate_en` → TX_LSB.
  - TX_LSB pushes result[7:0] → TX_MSB.
  - TX_MSB pushes result[15:8] → IDLE.
- Address is `rx_p_data[ADDR_W-1:0]`; the upper bits are ignored.
- TX push happens only when `fifo_full`=0. While the FIFO is full, the FSM holds its state and `tx_d_vld`=0.
- `rx_d_vld` arriving in RD_WAIT, ALU_WAIT, RD_TX, TX_LSB or TX_MSB is dropped; there is no queuing.
- `rd_data_vld` and `alu_out_vld` outside their wait states are ignored.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, FSM in IDLE.
- `RST` asserted mid-command aborts immediately, with no partial writes afterwards.
- Strobes (`wr_en`, `rd_en`, `tx_d_vld`) are exactly one cycle wide. Each is asserted the cycle after its triggering input strobe or state entry.
- `addr` and `wr_data` are valid in the same cycle as `wr_en`/`rd_en` and hold until the next access.
- `alu_fun` holds its value until the next FUN byte.
- `alu_en` and `clk_gate_en` rise the cycle after the FUN byte. They fall the cycle after `alu_out_vld`.
- Latency, assuming an idle FIFO:
  - Write: `wr_en` 1 cycle after the data byte.
  - Read: first TX push 1 cycle after `rd_data_vld`.
  - ALU: LSB push 1 cycle after capture, MSB push on the following cycle.
- Back-to-back commands are accepted from the cycle the FSM returns to IDLE.

## Structure
- Package `sys_ctrl_pkg`: opcode constants (`OP_WR`, `OP_RD`, `OP_ALU_OP`, `OP_ALU_NOP`), the state enum, and operand addresses `ADDR_OP_A`=0 and `ADDR_OP_B`=1.
- Single module; no sub-module. The FSM and output registers live in one file.

## Test plan
- Write: RX 0xAA, 0x05, 0x3C → one `wr_en` pulse with `addr`=5, `wr_data`=0x3C; no TX push.
- Read: RX 0xBB, 0x05, then `rd_data`=0x3C → `rd_en` pulse with `addr`=5, then one `tx_d_vld` with `tx_p_data`=0x3C.
- ALU with operands:
  - Stimulus: RX 0xCC, 0x12, 0x34, 0x00, then `alu_out`=0x0046 after 3 cycles.
  - Response: writes 0x12 to address 0 and 0x34 to address 1, `alu_fun`=0; `alu_en`/`clk_gate_en` high until capture; TX 0x46 then 0x00.
- FIFO backpressure: run 0xDD, 0x08 with `fifo_full`=1 held for 5 cycles after capture → no push while full; LSB and MSB pushed in order after release.
- Illegal opcode: RX 0x77, then 0xAA, 0x01, 0xFF → 0x77 is ignored; the write to address 1 of 0xFF completes normally.
- Reset mid-op: assert `RST` low in ALU_WAIT → all outputs 0 asynchronously; a later `alu_out_vld` produces no TX push.
